// File: rtl/tensor_acc_sequencer.sv
// tensor_acc_sequencer: runs an N-step MAC chain on the BF16 tensor unit,
// feeding each result back as the next C operand and returning the final vector.
module tensor_acc_sequencer #(
    parameter int LEN_W  = 8,
    parameter int TU_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [63:0]      cmd_c,
    input  logic             cmd_relu,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [63:0]      op_a,
    input  logic [63:0]      op_b,
    output logic             tu_en,
    output logic [63:0]      tu_a,
    output logic [63:0]      tu_b,
    output logic [63:0]      tu_c,
    output logic             tu_do_relu,
    input  logic [63:0]      tu_vector_out,
    input  logic             tu_valid_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic             busy,
    output logic             err_stray
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam int         CW  = $clog2(TU_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(TU_LAT);

    logic [1:0]       state;
    logic [63:0]      acc;
    logic [LEN_W-1:0] remaining;
    logic             relu_r;
    logic [CW-1:0]    wait_cnt;

    logic in_idle, in_fetch, in_wait, in_result;
    logic cmd_fire, op_fire, early, stray, take_res;

    assign in_idle   = (state == S_IDLE);
    assign in_fetch  = (state == S_FETCH);
    assign in_wait   = (state == S_WAIT);
    assign in_result = (state == S_RESULT);

    assign cmd_ready  = in_idle;
    assign op_ready   = in_fetch;
    assign res_valid  = in_result;
    assign busy       = !in_idle;
    assign res_data   = acc;

    assign tu_en      = in_fetch && op_valid;
    assign tu_a       = op_a;
    assign tu_b       = op_b;
    assign tu_c       = acc;
    assign tu_do_relu = in_fetch && relu_r && (remaining == LEN_W'(1));

    assign cmd_fire = cmd_valid && in_idle;
    assign op_fire  = op_valid && in_fetch;

    // A result earlier than the unit latency cannot belong to our issue.
    assign early    = (wait_cnt < LAT);
    assign stray    = !in_wait || early;
    assign take_res = tu_valid_out && in_wait && !early;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            remaining <= '0;
            relu_r    <= 1'b0;
            err_stray <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (tu_valid_out && stray) begin
                err_stray <= 1'b1;
            end else if (cmd_fire) begin
                err_stray <= 1'b0;
            end

            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        acc       <= cmd_c;
                        remaining <= cmd_len;
                        relu_r    <= cmd_relu;
                        state     <= (cmd_len != '0) ? S_FETCH : S_RESULT;
                    end
                end
                S_FETCH: begin
                    if (op_fire) begin
                        remaining <= remaining - LEN_W'(1);
                        wait_cnt  <= CW'(1);
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (take_res) begin
                        acc   <= tu_vector_out;
                        state <= (remaining != '0) ? S_FETCH : S_RESULT;
                    end else if (wait_cnt != LAT) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tensor_acc_sequencer.sv
// Scoreboard bench for tensor_acc_sequencer with a fixed-latency
// tensor-unit stub that returns scripted vectors.
module tb_tensor_acc_sequencer;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [63:0]      cmd_c = '0;
    logic             cmd_relu = 1'b0;
    logic             op_valid;
    logic             op_ready;
    logic [63:0]      op_a;
    logic [63:0]      op_b;
    logic             tu_en;
    logic [63:0]      tu_a, tu_b, tu_c;
    logic             tu_do_relu;
    logic [63:0]      tu_vector_out;
    logic             tu_valid_out;
    logic             res_valid;
    logic             res_ready;
    logic [63:0]      res_data;
    logic             busy;
    logic             err_stray;

    always #5 clk = ~clk;

    tensor_acc_sequencer #(.LEN_W(LEN_W), .TU_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_c(cmd_c), .cmd_relu(cmd_relu),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b),
        .tu_en(tu_en), .tu_a(tu_a), .tu_b(tu_b), .tu_c(tu_c),
        .tu_do_relu(tu_do_relu),
        .tu_vector_out(tu_vector_out), .tu_valid_out(tu_valid_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy), .err_stray(err_stray)
    );

    typedef struct {
        logic [63:0] c;
        logic        relu;
        int          cyc;
    } iss_t;

    typedef struct {
        logic [63:0] d;
        int          cyc;
    } res_t;

    iss_t        exp_iss[$];
    res_t        exp_res[$];
    logic [63:0] stub_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int iss_cnt = 0;
    int op_gap = 0, op_hold = 0;
    int res_gap = 0, res_hold = 0;
    bit hs_op = 0, prev_rv = 0, post_res = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", nm, $time);
    endtask

    // Tensor-unit stub: 3-cycle latency, not reset so stale results can appear.
    logic [2:0]  sv = '0;
    logic [63:0] sd0 = '0, sd1 = '0, sd2 = '0;
    logic        inj_v = 1'b0;
    logic [63:0] inj_d = '0;

    always @(posedge clk) begin
        logic [63:0] nv;
        nv = '0;
        if (tu_en && stub_q.size() > 0) nv = stub_q.pop_front();
        sv  <= {sv[1:0], tu_en};
        sd0 <= nv;
        sd1 <= sd0;
        sd2 <= sd1;
    end

    assign tu_valid_out  = sv[2] | inj_v;
    assign tu_vector_out = inj_v ? inj_d : sd2;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (post_res) begin
                chk("cmd_ready_after_res", 64'(cmd_ready), 64'd1);
                post_res = 0;
            end
            if (cmd_valid && cmd_ready) t0 = cyc;
            if (op_valid || tu_en)
                chk("tu_en_vs_handshake", 64'(tu_en), 64'(op_valid && op_ready));
            if (tu_en) begin
                iss_cnt++;
                if (exp_iss.size() == 0) begin
                    fail_now("unexpected_issue");
                end else begin
                    iss_t e;
                    e = exp_iss.pop_front();
                    chk("tu_c", tu_c, e.c);
                    chk("tu_do_relu", 64'(tu_do_relu), 64'(e.relu));
                    chk("tu_a_pass", tu_a, op_a);
                    if (e.cyc >= 0) chk("issue_cycle", 64'(cyc - t0), 64'(e.cyc));
                end
            end
            if (res_valid) begin
                if (exp_res.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    if (!prev_rv && exp_res[0].cyc >= 0)
                        chk("res_cycle", 64'(cyc - t0), 64'(exp_res[0].cyc));
                    if (res_ready) begin
                        chk("res_data", res_data, exp_res[0].d);
                        chk("cmd_ready_in_result", 64'(cmd_ready), 64'd0);
                        void'(exp_res.pop_front());
                        post_res = 1;
                    end else begin
                        chk("res_data_stall", res_data, exp_res[0].d);
                    end
                end
            end
            prev_rv = res_valid;
            hs_op   = op_valid && op_ready;
        end else begin
            prev_rv  = 0;
            hs_op    = 0;
            post_res = 0;
        end
    end

    // Operand source: optional gap before each pair
    initial begin
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        forever begin
            @(posedge clk);
            #1;
            if (hs_op) op_hold = op_gap;
            if (op_hold > 0) begin
                op_valid = 1'b0;
                op_hold--;
            end else begin
                op_valid = 1'b1;
            end
            op_a = {4{cyc[15:0]}};
            op_b = ~op_a;
        end
    end

    // Result sink: optional stall on each result
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (res_valid && res_hold > 0) begin
                res_ready = 1'b0;
                res_hold--;
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    task automatic send_cmd(input logic [LEN_W-1:0] len, input logic [63:0] c,
                            input logic relu);
        bit ok;
        ok = 0;
        op_hold  = op_gap;
        res_hold = res_gap;
        @(posedge clk);
        #2;
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_c     = c;
        cmd_relu  = relu;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("cmd_accept_timeout");
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_res.size() == 0 && exp_iss.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("completion_timeout");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_res_data"}, res_data, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err_stray"}, 64'(err_stray), 64'd0);
        chk({tag, "_tu_en"}, 64'(tu_en), 64'd0);
        chk({tag, "_op_ready"}, 64'(op_ready), 64'd0);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    localparam logic [63:0] C0 = 64'h3F80_3F80_3F80_3F80;
    localparam logic [63:0] R1 = 64'h4040_4040_4040_4040;
    localparam logic [63:0] R2 = 64'h4080_4080_4080_4080;
    localparam logic [63:0] R3 = 64'h40A0_40A0_40A0_40A0;
    localparam logic [63:0] CZ = 64'hBF80_0000_4000_3F80;

    initial begin
        int  n0;
        bit  seen;

        #12;
        chk_reset_outputs("por");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset in the middle of a 4-step command
        exp_iss.push_back('{C0, 1'b0, 1});
        stub_q.push_back(64'h5555_5555_5555_5555);
        send_cmd(8'd4, C0, 1'b0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tu_en) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_now("reset_test_issue_timeout");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("stale_result_err", 64'(err_stray), 64'd1);
        exp_iss.delete();
        stub_q.delete();

        // Three steps, back-to-back operands
        stub_q.push_back(R1);
        stub_q.push_back(R2);
        stub_q.push_back(R3);
        exp_iss.push_back('{C0, 1'b0, 1});
        exp_iss.push_back('{R1, 1'b0, 5});
        exp_iss.push_back('{R2, 1'b0, 9});
        exp_res.push_back('{R3, 13});
        send_cmd(8'd3, C0, 1'b0);
        chk("err_cleared_on_cmd", 64'(err_stray), 64'd0);
        wait_done();

        // ReLU only on the final step
        stub_q.push_back(64'h4000_4000_4000_4000);
        stub_q.push_back(64'h0000_4000_0000_4000);
        exp_iss.push_back('{C0, 1'b0, 1});
        exp_iss.push_back('{64'h4000_4000_4000_4000, 1'b1, 5});
        exp_res.push_back('{64'h0000_4000_0000_4000, 9});
        send_cmd(8'd2, C0, 1'b1);
        wait_done();

        // Same length without ReLU
        stub_q.push_back(64'h1234_5678_9ABC_DEF0);
        stub_q.push_back(64'h0FED_CBA9_8765_4321);
        exp_iss.push_back('{C0, 1'b0, 1});
        exp_iss.push_back('{64'h1234_5678_9ABC_DEF0, 1'b0, 5});
        exp_res.push_back('{64'h0FED_CBA9_8765_4321, 9});
        send_cmd(8'd2, C0, 1'b0);
        wait_done();

        // Zero length returns cmd_c untouched
        n0 = iss_cnt;
        exp_res.push_back('{CZ, 1});
        send_cmd(8'd0, CZ, 1'b1);
        wait_done();
        chk("zero_len_no_issue", 64'(iss_cnt - n0), 64'd0);

        // Operand and result backpressure
        op_gap  = 5;
        res_gap = 3;
        n0 = iss_cnt;
        stub_q.push_back(64'hAAAA_0001_AAAA_0001);
        stub_q.push_back(64'hBBBB_0002_BBBB_0002);
        exp_iss.push_back('{C0, 1'b0, -1});
        exp_iss.push_back('{64'hAAAA_0001_AAAA_0001, 1'b0, -1});
        exp_res.push_back('{64'hBBBB_0002_BBBB_0002, -1});
        send_cmd(8'd2, C0, 1'b0);
        wait_done();
        chk("bp_issue_count", 64'(iss_cnt - n0), 64'd2);
        res_gap = 0;

        // Stray result while waiting for operands
        op_gap = 8;
        stub_q.push_back(64'h7777_8888_9999_AAAA);
        exp_iss.push_back('{64'h0102_0304_0506_0708, 1'b0, -1});
        exp_res.push_back('{64'h7777_8888_9999_AAAA, -1});
        send_cmd(8'd1, 64'h0102_0304_0506_0708, 1'b0);
        @(posedge clk);
        #2;
        inj_v = 1'b1;
        inj_d = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk);
        #2;
        inj_v = 1'b0;
        @(negedge clk);
        chk("stray_err_set", 64'(err_stray), 64'd1);
        wait_done();
        chk("stray_err_sticky", 64'(err_stray), 64'd1);
        op_gap = 0;
        exp_res.push_back('{CZ, 1});
        send_cmd(8'd0, CZ, 1'b0);
        chk("stray_err_cleared", 64'(err_stray), 64'd0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
